io_dec_display: RTL and testbench
=================================

# io_dec_display

Output-side display stage for the single-cycle CPU's memory-mapped I/O. It consumes the low W bits of an output-port register (normally `out_port0[W-1:0]`) and converts the unsigned binary value to packed BCD with a sequential shift-add-3 (double-dabble) engine. It then time-multiplexes the decimal digits onto common-anode seven-segment displays. It sits directly downstream of the data-memory I/O output registers and drives board pins.

## Interface
- W, 16, binary input width (≥ 4)
- D, 5, decimal digit count; must satisfy 10^D > 2^W − 1
- SCAN_DIV, 50000, clock cycles each digit stays lit (≥ 2)
- clock  input  1  rising-edge clock; one clock domain only
- clr  input  1  synchronous reset, active-high
- value  input  W  unsigned binary value to display (from out_port register)
- busy  output  1  high while a conversion is in progress
- bcd  output  4*D  packed BCD of last converted value, digit 0 = bcd[3:0]
- an  output  D  digit enables, active-low, one-hot-low
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low

## Operation
- State machine with three states: IDLE, CONV, DONE.
  - IDLE: if `value != last_val`, load the shift register with {4D zeros, value}, set `last_val <= value`, clear bit counter `cnt`, and go to CONV. Otherwise stay in IDLE.
  - CONV: each cycle, add 3 to every BCD nibble of the shift register that is ≥ 5, then shift the whole register left by 1; increment `cnt`. When `cnt == W-1` on that edge, go to DONE.
  - DONE: `bcd <= BCD part of shift register`; go to IDLE.
- `value` changing during CONV/DONE is ignored until IDLE. It is then detected by the `last_val` compare, and exactly one new conversion starts. No value is lost if it is still present at IDLE.
- `busy = (state != IDLE)`.
- Scan logic:
  - `div` counts 0..SCAN_DIV-1 and wraps.
  - On wrap, digit index `idx` increments 0..D-1 and wraps to 0.
- Registered outputs, updated every clock from the current `idx`:
  - `an <= ~(1 << idx)`
  - `seg <= decode(bcd digit idx)`
- Decode table: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000. Nibbles 10–15 decode to 1111111 (blank); these are unreachable in normal operation.

## Timing
- Reset values:
  - state=IDLE, last_val=0, cnt=0, shift register=0
  - bcd=0, busy=0
  - div=0, idx=0
  - an = all ones, seg = 1111111
- Conversion latency: if `value` differs from `last_val` before edge t in IDLE:
  - edge t enters CONV;
  - edges t+1..t+W perform the W shift steps (edge t+W also enters DONE);
  - edge t+W+1 updates `bcd` and returns to IDLE.
  - `busy` is high from after edge t until edge t+W+1.
- `bcd` changes atomically, and only at the DONE edge. It never shows partial results.
- Back-to-back changes: the earliest next conversion can start at edge t+W+2.
- Display timing: each digit is held SCAN_DIV cycles; a full frame is D*SCAN_DIV cycles. `an`/`seg` lag `idx`/`bcd` by one clock.
- `clr` asserted mid-conversion: the next edge forces all reset values, and the conversion is abandoned. After `clr` drops, a nonzero `value` restarts conversion immediately (last_val=0).
- Value 0 after reset causes no conversion; `bcd` already equals 0.

## Configuration
- `DISP_LZB_EN` defined: leading-zero blanking.
  - Digit i (i ≥ 1) drives `seg` = 1111111 when it and all higher digits of `bcd` are 0.
  - Digit 0 is never blanked.
  - `an` scanning is unchanged.
- Not defined: all D digits always show their decoded value, leading zeros included.

## Test plan
- Reset: assert `clr` 3 cycles with value=1234 -> an=11111, seg=1111111, bcd=0, busy=0. After release, busy rises on the next edge and bcd=0x01234 exactly W+2 edges after release.
- Max value (W=16): value=65535 -> bcd=0x65535 at t+17. busy high exactly 17 cycles.
- Mid-conversion change: value 100 -> 250 at t+5 -> bcd=0x00100 at t+17. Second conversion starts at t+18. bcd=0x00250 at t+35.
- Scan (SCAN_DIV=4, bcd=0x12345): `an` sequence 11110, 11101, 11011, 10111, 01111, each held 4 cycles, repeating. `seg` = 0010010, 0011001, 0110000, 0100100, 1111001 in step.
- With `DISP_LZB_EN`, value=7 -> digit 0 seg=1111000, digits 1–4 seg=1111111. Without it, digits 1–4 show 1000000.
- Reset mid-conversion: pulse `clr` at t+8 of a conversion for 40000 -> bcd=0, busy=0. New conversion starts the edge after release and yields bcd=0x40000.

Source files
------------

// File: rtl/io_dec_display.sv
// Display stage: binary to packed BCD via sequential double-dabble, then multiplexed
// common-anode seven-segment scan. Define DISP_LZB_EN to enable leading-zero blanking.
module io_dec_display #(
    parameter int unsigned W        = 16,
    parameter int unsigned D        = 5,
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic             clock,
    input  logic             clr,
    input  logic [W-1:0]     value,
    output logic             busy,
    output logic [4*D-1:0]   bcd,
    output logic [D-1:0]     an,
    output logic [6:0]       seg
);

    localparam int unsigned SR_W  = W + 4 * D;
    localparam int unsigned CNT_W = $clog2(W);
    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam int unsigned IDX_W = (D > 1) ? $clog2(D) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [SR_W-1:0]    r_sr;
    logic [SR_W-1:0]    w_adj;
    logic [SR_W-1:0]    w_shift;
    logic [W-1:0]       r_last_val;
    logic [CNT_W-1:0]   r_cnt;
    logic [4*D-1:0]     r_bcd;
    logic               r_busy;
    logic [DIV_W-1:0]   r_div;
    logic [IDX_W-1:0]   r_idx;
    logic [D-1:0]       r_an;
    logic [6:0]         r_seg;
    logic [3:0]         w_digit;
    logic               w_blank;
    logic [6:0]         w_seg;

    // Seven-segment decode, {g,f,e,d,c,b,a}, active-low; non-decimal nibbles blank
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // State register
    always_ff @(posedge clock) begin
        if (clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (value != r_last_val) begin
                    w_next_state = S_CONV;
                end
            end
            S_CONV: begin
                if (r_cnt == CNT_W'(W - 1)) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left
    always_comb begin
        w_adj = r_sr;
        for (int i = 0; i < int'(D); i++) begin
            if (r_sr[W + 4*i +: 4] >= 4'd5) begin
                w_adj[W + 4*i +: 4] = r_sr[W + 4*i +: 4] + 4'd3;
            end
        end
        w_shift = w_adj << 1;
    end

    // Conversion datapath; bcd only updates in DONE so it never shows partial results
    always_ff @(posedge clock) begin
        if (clr) begin
            r_sr       <= '0;
            r_last_val <= '0;
            r_cnt      <= '0;
            r_bcd      <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_busy <= (w_next_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (value != r_last_val) begin
                        r_sr       <= {{(4*D){1'b0}}, value};
                        r_last_val <= value;
                        r_cnt      <= '0;
                    end
                end
                S_CONV: begin
                    r_sr  <= w_shift;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                S_DONE: begin
                    r_bcd <= r_sr[SR_W-1 -: 4*D];
                end
                default: ;
            endcase
        end
    end

    // Digit scan counters
    always_ff @(posedge clock) begin
        if (clr) begin
            r_div <= '0;
            r_idx <= '0;
        end else if (r_div == DIV_W'(SCAN_DIV - 1)) begin
            r_div <= '0;
            r_idx <= (r_idx == IDX_W'(D - 1)) ? '0 : r_idx + IDX_W'(1);
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

`ifdef DISP_LZB_EN
    logic [D-1:0] w_hi_zero;

    // w_hi_zero[i]: digit i and every digit above it are zero
    always_comb begin
        w_hi_zero        = '0;
        w_hi_zero[D-1]   = (r_bcd[4*(D-1) +: 4] == 4'd0);
        for (int i = int'(D) - 2; i >= 0; i--) begin
            w_hi_zero[i] = w_hi_zero[i+1] && (r_bcd[4*i +: 4] == 4'd0);
        end
    end
`endif

    // Select the active digit and decide whether it is blanked
    always_comb begin
        w_digit = 4'd0;
        w_blank = 1'b0;
        for (int i = 0; i < int'(D); i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_digit = r_bcd[4*i +: 4];
`ifdef DISP_LZB_EN
                w_blank = (i != 0) && w_hi_zero[i];
`endif
            end
        end
        w_seg = w_blank ? 7'b1111111 : seg_decode(w_digit);
    end

    // Registered pin drivers, one clock behind idx/bcd
    always_ff @(posedge clock) begin
        if (clr) begin
            r_an  <= '1;
            r_seg <= 7'b1111111;
        end else begin
            r_an  <= ~(D'(1) << r_idx);
            r_seg <= w_seg;
        end
    end

    assign busy = r_busy;
    assign bcd  = r_bcd;
    assign an   = r_an;
    assign seg  = r_seg;

endmodule

// File: tb/tb_io_dec_display.sv
// Self-checking bench for io_dec_display (W=16, D=5, SCAN_DIV=4) with an expected-BCD
// scoreboard queue; follows DISP_LZB_EN when the bench is built with it.
module tb_io_dec_display;

    localparam int unsigned W        = 16;
    localparam int unsigned D        = 5;
    localparam int unsigned SCAN_DIV = 4;

    logic          clock = 1'b0;
    logic          clr   = 1'b1;
    logic [W-1:0]  value = '0;
    logic          busy;
    logic [19:0]   bcd;
    logic [4:0]    an;
    logic [6:0]    seg;

    int checks   = 0;
    int failures = 0;

    logic [19:0] exp_q [$];
    logic [6:0]  seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                  7'b0000000, 7'b0010000};

    io_dec_display #(.W(W), .D(D), .SCAN_DIV(SCAN_DIV)) dut (
        .clock (clock),
        .clr   (clr),
        .value (value),
        .busy  (busy),
        .bcd   (bcd),
        .an    (an),
        .seg   (seg)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset;
        logic [19:0] e;
        clr   = 1'b1;
        value = 16'd1234;
        repeat (3) tick();
        checks++; if (an !== 5'b11111) begin failures++; $display("FAIL reset_an got=%b exp=%b", an, 5'b11111); end
        checks++; if (seg !== 7'b1111111) begin failures++; $display("FAIL reset_seg got=%b exp=%b", seg, 7'b1111111); end
        checks++; if (bcd !== 20'h0) begin failures++; $display("FAIL reset_bcd got=%h exp=%h", bcd, 20'h0); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=%b", busy, 1'b0); end
        exp_q.push_back(20'h01234);
        clr = 1'b0;
        tick();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL reset_busy_rise got=%b exp=%b", busy, 1'b1); end
        for (int n = 2; n <= int'(W) + 2; n++) begin
            tick();
            if (n == int'(W) + 1) begin
                checks++; if (bcd !== 20'h0 || busy !== 1'b1) begin failures++; $display("FAIL reset_early got bcd=%h busy=%b exp bcd=%h busy=1", bcd, busy, 20'h0); end
            end
        end
        e = exp_q.pop_front();
        checks++; if (bcd !== e) begin failures++; $display("FAIL reset_conv got=%h exp=%h", bcd, e); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_conv_busy got=%b exp=%b", busy, 1'b0); end
    endtask

    task automatic test_max;
        logic [19:0] e;
        int cyc;
        value = 16'd65535;
        exp_q.push_back(20'h65535);
        tick();
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            tick();
        end
        checks++; if (cyc != 17) begin failures++; $display("FAIL max_busy_len got=%0d exp=%0d", cyc, 17); end
        e = exp_q.pop_front();
        checks++; if (bcd !== e) begin failures++; $display("FAIL max_bcd got=%h exp=%h", bcd, e); end
    endtask

    task automatic test_mid_change;
        logic [19:0] e;
        value = 16'd100;
        exp_q.push_back(20'h00100);
        tick();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy got=%b exp=%b", busy, 1'b1); end
        for (int n = 1; n <= 35; n++) begin
            tick();
            if (n == 4) begin
                value = 16'd250;
                exp_q.push_back(20'h00250);
            end
            if (n == 16) begin
                checks++; if (bcd !== 20'h65535) begin failures++; $display("FAIL mid_hold got=%h exp=%h", bcd, 20'h65535); end
            end
            if (n == 17) begin
                e = exp_q.pop_front();
                checks++; if (bcd !== e || busy !== 1'b0) begin failures++; $display("FAIL mid_first got bcd=%h busy=%b exp bcd=%h busy=0", bcd, busy, e); end
            end
            if (n == 18) begin
                checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_restart got=%b exp=%b", busy, 1'b1); end
            end
            if (n == 34) begin
                checks++; if (bcd !== 20'h00100) begin failures++; $display("FAIL mid_hold2 got=%h exp=%h", bcd, 20'h00100); end
            end
            if (n == 35) begin
                e = exp_q.pop_front();
                checks++; if (bcd !== e) begin failures++; $display("FAIL mid_second got=%h exp=%h", bcd, e); end
            end
        end
    endtask

    task automatic test_scan;
        logic [15:0] vals [2] = '{16'd12345, 16'd65089};
        logic [19:0] bcds [2] = '{20'h12345, 20'h65089};
        logic [19:0] e;
        logic [4:0]  prev;
        logic [4:0]  ea;
        logic [6:0]  es;
        int cyc;
        int dig;
        bit found;
        for (int v = 0; v < 2; v++) begin
            value = vals[v];
            exp_q.push_back(bcds[v]);
            tick();
            cyc = 0;
            while (busy === 1'b1 && cyc < 100) begin
                cyc++;
                tick();
            end
            e = exp_q.pop_front();
            checks++; if (bcd !== e) begin failures++; $display("FAIL scan_bcd got=%h exp=%h", bcd, e); end
            // Align to the first cycle of digit 0
            prev  = an;
            found = 1'b0;
            for (int k = 0; k < 200 && !found; k++) begin
                tick();
                if (prev === 5'b01111 && an === 5'b11110) found = 1'b1;
                else prev = an;
            end
            checks++; if (!found) begin failures++; $display("FAIL scan_sync got an=%b exp wrap to %b", an, 5'b11110); end
            for (int k = 0; k < 2 * int'(D * SCAN_DIV); k++) begin
                if (k > 0) tick();
                dig = (k / int'(SCAN_DIV)) % int'(D);
                ea  = ~(5'b00001 << dig);
                es  = seg_tab[e[4*dig +: 4]];
                checks++; if (an !== ea || seg !== es) begin failures++; $display("FAIL scan_k%0d got an=%b seg=%b exp an=%b seg=%b", k, an, seg, ea, es); end
            end
        end
    endtask

    task automatic test_lzb;
        logic [19:0] e;
        logic [4:0]  prev;
        logic [6:0]  es;
        int cyc;
        int dig;
        bit found;
        value = 16'd7;
        exp_q.push_back(20'h00007);
        tick();
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            tick();
        end
        e = exp_q.pop_front();
        checks++; if (bcd !== e) begin failures++; $display("FAIL lzb_bcd got=%h exp=%h", bcd, e); end
        prev  = an;
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            tick();
            if (prev === 5'b01111 && an === 5'b11110) found = 1'b1;
            else prev = an;
        end
        checks++; if (!found) begin failures++; $display("FAIL lzb_sync got an=%b exp wrap to %b", an, 5'b11110); end
        for (int k = 0; k < int'(D * SCAN_DIV); k++) begin
            if (k > 0) tick();
            dig = k / int'(SCAN_DIV);
`ifdef DISP_LZB_EN
            es = (dig == 0) ? 7'b1111000 : 7'b1111111;
`else
            es = (dig == 0) ? 7'b1111000 : 7'b1000000;
`endif
            checks++; if (seg !== es) begin failures++; $display("FAIL lzb_k%0d got seg=%b exp seg=%b", k, seg, es); end
        end
    endtask

    task automatic test_reset_mid;
        logic [19:0] e;
        value = 16'd40000;
        exp_q.push_back(20'h40000);
        tick();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rmid_busy got=%b exp=%b", busy, 1'b1); end
        repeat (7) tick();
        clr = 1'b1;
        tick();
        checks++; if (bcd !== 20'h0 || busy !== 1'b0) begin failures++; $display("FAIL rmid_clear got bcd=%h busy=%b exp bcd=%h busy=0", bcd, busy, 20'h0); end
        checks++; if (an !== 5'b11111 || seg !== 7'b1111111) begin failures++; $display("FAIL rmid_pins got an=%b seg=%b exp an=11111 seg=1111111", an, seg); end
        // Abandoned conversion never produces a result; the same value reconverts
        exp_q.delete();
        exp_q.push_back(20'h40000);
        clr = 1'b0;
        tick();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rmid_restart got=%b exp=%b", busy, 1'b1); end
        repeat (W) tick();
        checks++; if (bcd !== 20'h0) begin failures++; $display("FAIL rmid_early got=%h exp=%h", bcd, 20'h0); end
        tick();
        e = exp_q.pop_front();
        checks++; if (bcd !== e || busy !== 1'b0) begin failures++; $display("FAIL rmid_conv got bcd=%h busy=%b exp bcd=%h busy=0", bcd, busy, e); end
    endtask

    initial begin
        test_reset();
        test_max();
        test_mid_change();
        test_scan();
        test_lzb();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
